// File: rtl/uart_pkg.sv
// Shared UART definitions: baud divisors at 12 MHz, receiver states, frame lengths
// and a bit-order helper used by the deframer.
package uart_pkg;

   localparam int BAUD_DIV_115200 = 104;
   localparam int BAUD_DIV_57600  = 208;
   localparam int BAUD_DIV_9600   = 1250;

   localparam int NB_8N1 = 10;
   localparam int NB_8E1 = 11;

   typedef enum logic [1:0] {
      IDLE,
      RECV,
      LOAD,
      DAV
   } rx_state_t;

   // The line carries data LSB first but the shift register fills MSB first,
   // so the captured byte comes out mirrored.
   function automatic logic [7:0] bit_reverse8(input logic [7:0] v);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) begin
         r[i] = v[7-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/uart_rx_midtick.sv
// Mid-bit sample tick generator: first tick BAUD_DIV>>1 cycles after tick_en rises,
// then one tick every BAUD_DIV cycles while tick_en stays high.
module uart_rx_midtick #(
   parameter int BAUD_DIV = 104
) (
   input  logic clk,
   input  logic rst,
   input  logic tick_en,
   output logic tick
);

   localparam int CW = $clog2(BAUD_DIV);
   localparam logic [CW-1:0] HALF = CW'(BAUD_DIV >> 1);
   localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || !tick_en) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = tick_en && (cnt == HALF);

endmodule

// File: rtl/uart_rx_deframer.sv
// 8N1 UART receiver: synchronises rx, frames bits on mid-bit ticks and strobes rcv.
// Define UART_RX_PARITY_EN for 8E1 frames with a parity error flag on perr.
module uart_rx_deframer
   import uart_pkg::*;
#(
   parameter int BAUD_DIV    = 104,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       rcv,
   output logic       ferr,
   output logic       perr,
   output logic       busy
);

`ifdef UART_RX_PARITY_EN
   localparam int NB = NB_8E1;
`else
   localparam int NB = NB_8N1;
`endif
   localparam logic [3:0] LAST_BIT = 4'(NB - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rx_s;
   rx_state_t              state;
   logic [NB-2:0]          shreg;
   logic [3:0]             bit_cnt;
   logic                   tick_en;
   logic                   tick;

   // Synchroniser flops idle high so reset never looks like a start bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      end
   end

   assign rx_s = sync_q[SYNC_STAGES-1];

   uart_rx_midtick #(
      .BAUD_DIV(BAUD_DIV)
   ) u_midtick (
      .clk     (clk),
      .rst     (rst),
      .tick_en (tick_en),
      .tick    (tick)
   );

   // The start bit shifts through and falls off the top, leaving data,
   // optional parity and stop in the register when the frame completes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         data    <= 8'h00;
         rcv     <= 1'b0;
         ferr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr    <= 1'b0;
`endif
         shreg   <= '0;
         bit_cnt <= 4'd0;
         tick_en <= 1'b0;
      end else begin
         rcv <= 1'b0;
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state   <= RECV;
                  tick_en <= 1'b1;
                  bit_cnt <= 4'd0;
               end
            end
            RECV: begin
               if (tick) begin
                  if (bit_cnt == 4'd0 && rx_s) begin
                     state   <= IDLE;
                     tick_en <= 1'b0;
                  end else begin
                     shreg   <= {shreg[NB-3:0], rx_s};
                     bit_cnt <= bit_cnt + 4'd1;
                     if (bit_cnt == LAST_BIT) begin
                        state <= LOAD;
                     end
                  end
               end
            end
            LOAD: begin
               tick_en <= 1'b0;
               data    <= bit_reverse8(shreg[NB-2 -: 8]);
               ferr    <= ~shreg[0];
`ifdef UART_RX_PARITY_EN
               perr    <= ^shreg[NB-2:1];
`endif
               rcv     <= 1'b1;
               state   <= DAV;
            end
            DAV: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifndef UART_RX_PARITY_EN
   assign perr = 1'b0;
`endif

   assign busy = (state == RECV) || (state == LOAD);

endmodule
